// File: rtl/nn_layer_engine.sv
// nn_layer_engine: fully-connected NN layer over an Avalon-MM master; define NN_RELU_EN to write negative results as 0
module nn_layer_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32,
    parameter int ACC_W = 40,
    parameter int N_IN = 784,
    parameter int N_NODE = 200,
    parameter logic [ADDR_W-1:0] BASE_W = 'h00F1C492,
    parameter logic [ADDR_W-1:0] BASE_X = 'h00028292,
    parameter logic [ADDR_W-1:0] BASE_Y = 'h000132A2,
    parameter int START_DLY = 100000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ready,
    input  logic                mode,
    input  logic                waitrequest,
    input  logic                readdatavalid,
    input  logic [DATA_W-1:0]   readdata,
    output logic                read_n,
    output logic                write_n,
    output logic                chipselect,
    output logic [DATA_W/8-1:0] byteenable,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   writedata,
    output logic                done,
    output logic                busy,
    output logic [3:0]          state_dbg
);
    typedef enum logic [3:0] {IDLE, DELAY, ARM, RD_W, WT_W, RD_X, WT_X, MAC, WR, NEXT, DONE} state_t;
    localparam int DW = $clog2(START_DLY + 1);
    localparam int IW = $clog2(N_IN + 1);
    localparam int NW = $clog2(N_NODE + 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
    state_t state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [IW-1:0] in_cnt_q, in_cnt_d;
    logic [NW-1:0] node_cnt_q, node_cnt_d;
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d, x_ptr_q, x_ptr_d, y_ptr_q, y_ptr_d;
    logic signed [DATA_W-1:0] w_q, w_d, x_q, x_d;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [DATA_W-1:0] wdata_q, wdata_d, sat, res;
    logic mode_q, mode_d, fits;
    assign prod = w_q * x_q;
    assign acc_sum = mode_q ? acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod}
                   : (x_q != '0) ? acc_q + {{(ACC_W-DATA_W){w_q[DATA_W-1]}}, w_q} : acc_q;
    assign fits = &acc_sum[ACC_W-1:DATA_W-1] | ~|acc_sum[ACC_W-1:DATA_W-1];
    assign sat = fits ? acc_sum[DATA_W-1:0] : {acc_sum[ACC_W-1], {(DATA_W-1){~acc_sum[ACC_W-1]}}};
`ifdef NN_RELU_EN
    assign res = acc_sum[ACC_W-1] ? '0 : sat;
`else
    assign res = sat;
`endif
    always_comb begin
        state_d = state_q;
        dly_d = dly_q;
        in_cnt_d = in_cnt_q;
        node_cnt_d = node_cnt_q;
        w_ptr_d = w_ptr_q;
        x_ptr_d = x_ptr_q;
        y_ptr_d = y_ptr_q;
        w_d = w_q;
        x_d = x_q;
        acc_d = acc_q;
        wdata_d = wdata_q;
        mode_d = mode_q;
        case (state_q)
            IDLE: begin
                state_d = DELAY;
                dly_d = '0;
            end
            DELAY: begin
                state_d = (dly_q == DW'(START_DLY - 1)) ? ARM : DELAY;
                dly_d = (dly_q == DW'(START_DLY - 1)) ? '0 : dly_q + 1'b1;
            end
            ARM: begin
                state_d = ready ? RD_W : DELAY;
                mode_d = ready ? mode : mode_q;
            end
            RD_W: state_d = waitrequest ? RD_W : WT_W;
            WT_W: if (readdatavalid) begin
                w_d = $signed(readdata);
                w_ptr_d = w_ptr_q + STEP;
                state_d = RD_X;
            end
            RD_X: state_d = waitrequest ? RD_X : WT_X;
            WT_X: if (readdatavalid) begin
                x_d = $signed(readdata);
                x_ptr_d = x_ptr_q + STEP;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_sum;
                wdata_d = res;
                in_cnt_d = in_cnt_q + 1'b1;
                state_d = (in_cnt_q == IW'(N_IN - 1)) ? WR : RD_W;
            end
            WR: if (!waitrequest) begin
                y_ptr_d = y_ptr_q + STEP;
                node_cnt_d = node_cnt_q + 1'b1;
                in_cnt_d = '0;
                state_d = NEXT;
            end
            NEXT: begin
                acc_d = '0;
                x_ptr_d = BASE_X;
                state_d = (node_cnt_q < NW'(N_NODE)) ? RD_W : DONE;
            end
            DONE: if (!ready) begin
                state_d = IDLE;
                in_cnt_d = '0;
                node_cnt_d = '0;
                w_ptr_d = BASE_W;
                x_ptr_d = BASE_X;
                y_ptr_d = BASE_Y;
                acc_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dly_q <= '0;
            in_cnt_q <= '0;
            node_cnt_q <= '0;
            w_ptr_q <= BASE_W;
            x_ptr_q <= BASE_X;
            y_ptr_q <= BASE_Y;
            w_q <= '0;
            x_q <= '0;
            acc_q <= '0;
            wdata_q <= '0;
            mode_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q <= dly_d;
            in_cnt_q <= in_cnt_d;
            node_cnt_q <= node_cnt_d;
            w_ptr_q <= w_ptr_d;
            x_ptr_q <= x_ptr_d;
            y_ptr_q <= y_ptr_d;
            w_q <= w_d;
            x_q <= x_d;
            acc_q <= acc_d;
            wdata_q <= wdata_d;
            mode_q <= mode_d;
        end
    end
    assign read_n = !(state_q == RD_W || state_q == RD_X);
    assign write_n = state_q != WR;
    assign chipselect = 1'b1;
    assign byteenable = '1;
    assign address = (state_q == RD_W) ? w_ptr_q : (state_q == RD_X) ? x_ptr_q : y_ptr_q;
    assign writedata = wdata_q;
    assign done = state_q == DONE;
    assign busy = !(state_q == IDLE || state_q == DONE);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_nn_layer_engine.sv
// tb_nn_layer_engine: directed bench with an Avalon slave memory model for nn_layer_engine
module tb_nn_layer_engine;
    localparam logic [31:0] BW = 32'h00F1C492;
    localparam logic [31:0] BX = 32'h00028292;
    localparam logic [31:0] BY = 32'h000132A2;
`ifdef NN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ready = 1'b0;
    logic mode = 1'b0;
    logic waitrequest, readdatavalid, read_n, write_n, chipselect, done, busy;
    logic [15:0] readdata, writedata;
    logic [1:0] byteenable;
    logic [31:0] address;
    logic [3:0] state_dbg;
    logic [15:0] mem [logic [31:0]];
    logic [31:0] wr_addr [64];
    logic [15:0] wr_data [64];
    logic rdv = 1'b0;
    logic [15:0] rdata = '0;
    int wait_cfg = 0;
    int wcnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int stall_cnt = 0;
    int hold_bad = 0;
    logic hold_chk = 1'b0;
    logic hold_rd = 1'b1;
    logic hold_wr = 1'b1;
    logic [31:0] hold_addr = '0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nn_layer_engine #(
        .DATA_W(16), .ADDR_W(32), .ACC_W(40), .N_IN(4), .N_NODE(2),
        .BASE_W(BW), .BASE_X(BX), .BASE_Y(BY), .START_DLY(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .mode(mode),
        .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata),
        .read_n(read_n), .write_n(write_n), .chipselect(chipselect), .byteenable(byteenable),
        .address(address), .writedata(writedata), .done(done), .busy(busy), .state_dbg(state_dbg)
    );

    assign waitrequest = (!read_n || !write_n) && (wcnt < wait_cfg);
    assign readdatavalid = rdv;
    assign readdata = rdata;

    always @(posedge clk) begin
        hold_chk <= (!read_n || !write_n) && waitrequest;
        hold_addr <= address;
        hold_rd <= read_n;
        hold_wr <= write_n;
        if ((!read_n || !write_n) && waitrequest) begin
            wcnt <= wcnt + 1;
            stall_cnt <= stall_cnt + 1;
        end else
            wcnt <= 0;
        rdv <= 1'b0;
        if (!read_n && !waitrequest) begin
            rdv <= 1'b1;
            rdata <= mem.exists(address) ? mem[address] : 16'hDEAD;
            rd_cnt <= rd_cnt + 1;
        end
        if (!write_n && !waitrequest) begin
            wr_addr[wr_cnt % 64] <= address;
            wr_data[wr_cnt % 64] <= writedata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    always @(negedge clk)
        if (hold_chk && (address !== hold_addr || read_n !== hold_rd || write_n !== hold_wr))
            hold_bad <= hold_bad + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [3:0] s, input int lim);
        int k = 0;
        while (state_dbg !== s && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " reach state"}, state_dbg, s);
    endtask

    task automatic load(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7, x0, x1, x2, x3);
        mem[BW] = w0; mem[BW+2] = w1; mem[BW+4] = w2; mem[BW+6] = w3;
        mem[BW+8] = w4; mem[BW+10] = w5; mem[BW+12] = w6; mem[BW+14] = w7;
        mem[BX] = x0; mem[BX+2] = x1; mem[BX+4] = x2; mem[BX+6] = x3;
    endtask

    task automatic check_run(input string tag, input int rb, input int wb, input int sb,
                             input logic [15:0] e0, input logic [15:0] e1, input int stalls);
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " reads"}, rd_cnt - rb, 16);
        chk({tag, " writes"}, wr_cnt - wb, 2);
        chk({tag, " y0 addr"}, wr_addr[wb % 64], BY);
        chk({tag, " y0"}, wr_data[wb % 64], e0);
        chk({tag, " y1 addr"}, wr_addr[(wb + 1) % 64], BY + 2);
        chk({tag, " y1"}, wr_data[(wb + 1) % 64], e1);
        chk({tag, " stalls"}, stall_cnt - sb, stalls);
    endtask

    task automatic run(input string tag, input logic m, input bit flip,
                       input logic [15:0] e0, input logic [15:0] e1, input int stalls);
        int rb, wb, sb;
        rb = rd_cnt;
        wb = wr_cnt;
        sb = stall_cnt;
        mode = m;
        ready = 1'b1;
        if (flip) begin
            wait_state({tag, " rd_w"}, 4'd3, 100);
            mode = ~m;
        end
        wait_state(tag, 4'd10, 3000);
        check_run(tag, rb, wb, sb, e0, e1, stalls);
    endtask

    task automatic drop_ready(input string tag);
        ready = 1'b0;
        @(negedge clk);
        chk({tag, " idle after drop"}, state_dbg, 4'd0);
        chk({tag, " addr rewound"}, address, BY);
    endtask

    initial begin
        int rb, wb, sb;
        @(negedge clk);
        chk("rst state", state_dbg, 4'd0);
        chk("rst read_n", read_n, 1'b1);
        chk("rst write_n", write_n, 1'b1);
        chk("rst done", done, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst address", address, BY);
        chk("rst writedata", writedata, 16'h0000);
        chk("chipselect", chipselect, 1'b1);
        chk("byteenable", byteenable, 2'b11);
        load(16'd1, 16'd2, 16'd3, 16'd4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
             16'd1, 16'd1, 16'd2, 16'd0);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no start without ready", rd_cnt, 0);

        run("mac", 1'b1, 1'b0, 16'd9, RELU ? 16'h0000 : 16'hFFFC, 0);
        rb = rd_cnt;
        repeat (10) @(negedge clk);
        chk("hold in done", state_dbg, 4'd10);
        chk("no restart reads", rd_cnt - rb, 0);
        drop_ready("mac");

        run("binary", 1'b0, 1'b1, 16'd6, RELU ? 16'h0000 : 16'hFFFD, 0);
        drop_ready("binary");

        load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
             16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run("sat", 1'b1, 1'b0, 16'h7FFF, RELU ? 16'h0000 : 16'h8000, 0);
        drop_ready("sat");

        load(16'd1, 16'd2, 16'd3, 16'd4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
             16'd1, 16'd1, 16'd2, 16'd0);
        wait_cfg = 5;
        run("wait", 1'b1, 1'b0, 16'd9, RELU ? 16'h0000 : 16'hFFFC, 90);
        chk("wait hold stable", hold_bad, 0);
        drop_ready("wait");
        wait_cfg = 0;

        mode = 1'b1;
        ready = 1'b1;
        wait_state("rst mid", 4'd6, 200);
        chk("rdv pending", readdatavalid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst mid state", state_dbg, 4'd0);
        chk("rst mid read_n", read_n, 1'b1);
        chk("rst mid write_n", write_n, 1'b1);
        chk("rst mid busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rb = rd_cnt;
        wb = wr_cnt;
        sb = stall_cnt;
        reset_n = 1'b1;
        wait_state("rerun", 4'd10, 3000);
        check_run("rerun", rb, wb, sb, 16'd9, RELU ? 16'h0000 : 16'hFFFC, 0);
        drop_ready("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
